// File: rtl/cam_downsampler.sv
// -----------------------------------------------------------------------------
// cam_downsampler
//   Capture front end for an OV7670-style camera. It takes the RGB565 byte
//   stream, two bytes per pixel, on the camera pixel clock. Each pixel is packed
//   to RGB332 (RRR_GGG_BB). For every pixel that falls inside a
//   SCREEN_WIDTH x SCREEN_HEIGHT window, the block issues a single-cycle
//   frame-buffer write strobe together with the column, row and linear address.
//
// Ports
//   CLK         in   camera pixel clock; all logic runs on its rising edge
//   RESET_N     in   asynchronous active-low reset
//   CAM_DATA    in   camera byte bus
//   CAM_HREF    in   high while line bytes are valid
//   CAM_VSYNC   in   high during vertical blanking
//   PIXEL_OUT   out  RGB332 pixel of the current write (held between writes)
//   W_EN        out  one-cycle write strobe per accepted pixel
//   X_ADDR      out  column of the current write
//   Y_ADDR      out  row of the current write
//   WRITE_ADDR  out  Y_ADDR*SCREEN_WIDTH + X_ADDR, built from a running line base
//   FRAME_DONE  out  one-cycle pulse after VSYNC rises on a frame that held lines
// -----------------------------------------------------------------------------
module cam_downsampler #(
    parameter int SCREEN_WIDTH  = 176,
    parameter int SCREEN_HEIGHT = 144,
    parameter int ADDR_W        = 15
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [7:0]        CAM_DATA,
    input  logic              CAM_HREF,
    input  logic              CAM_VSYNC,
    output logic [7:0]        PIXEL_OUT,
    output logic              W_EN,
    output logic [9:0]        X_ADDR,
    output logic [9:0]        Y_ADDR,
    output logic [ADDR_W-1:0] WRITE_ADDR,
    output logic              FRAME_DONE
);

    localparam logic [9:0]        LP_W10  = 10'(SCREEN_WIDTH);
    localparam logic [9:0]        LP_H10  = 10'(SCREEN_HEIGHT);
    localparam logic [ADDR_W-1:0] LP_W_AD = ADDR_W'(SCREEN_WIDTH);

    typedef enum logic [1:0] {
        ST_VBLANK    = 2'd0,
        ST_LINE_IDLE = 2'd1,
        ST_BYTE0     = 2'd2,
        ST_BYTE1     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_armed;      // a VSYNC-high period has been seen since reset
    logic              r_vsync_d;    // previous VSYNC sample for rise detection
    logic [7:0]        r_hi;
    logic [9:0]        r_x;
    logic [9:0]        r_y;
    logic [ADDR_W-1:0] r_base;       // y * SCREEN_WIDTH, kept as a running sum
    logic              r_line_px;    // current line completed at least one pixel

    logic [7:0]        r_pixel;
    logic              r_wen;
    logic [9:0]        r_xo;
    logic [9:0]        r_yo;
    logic [ADDR_W-1:0] r_addr;
    logic              r_frame_done;

    logic              w_clear;
    logic              w_hi_latch;
    logic              w_pix_done;
    logic              w_line_end;
    logic              w_vs_rise;
    logic              w_in_window;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_VBLANK;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; VSYNC high wins over everything. The first HREF-high
    // byte of a line is consumed in LINE_IDLE as the hi byte, so the pixel
    // pairing starts on that byte.
    always_comb begin
        w_next_state = r_state;
        if (CAM_VSYNC) begin
            w_next_state = ST_VBLANK;
        end else begin
            case (r_state)
                ST_VBLANK:    if (r_armed)  w_next_state = ST_LINE_IDLE; else w_next_state = ST_VBLANK;
                ST_LINE_IDLE: if (CAM_HREF) w_next_state = ST_BYTE1;     else w_next_state = ST_LINE_IDLE;
                ST_BYTE0:     if (CAM_HREF) w_next_state = ST_BYTE1;     else w_next_state = ST_LINE_IDLE;
                ST_BYTE1:     if (CAM_HREF) w_next_state = ST_BYTE0;     else w_next_state = ST_LINE_IDLE;
                default:      w_next_state = ST_VBLANK;
            endcase
        end
    end

    // Per-cycle datapath controls decoded from state and the camera strobes
    always_comb begin
        w_clear    = (r_state == ST_VBLANK);
        w_hi_latch = !CAM_VSYNC && CAM_HREF &&
                     ((r_state == ST_LINE_IDLE) || (r_state == ST_BYTE0));
        w_pix_done = !CAM_VSYNC && CAM_HREF && (r_state == ST_BYTE1);
        w_line_end = !CAM_VSYNC && !CAM_HREF &&
                     ((r_state == ST_BYTE0) || (r_state == ST_BYTE1));
    end

    assign w_vs_rise   = CAM_VSYNC && !r_vsync_d;
    assign w_in_window = (r_x < LP_W10) && (r_y < LP_H10);

    // Counters, byte capture and registered write/frame outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_armed      <= 1'b0;
            r_vsync_d    <= 1'b0;
            r_hi         <= 8'h00;
            r_x          <= 10'd0;
            r_y          <= 10'd0;
            r_base       <= '0;
            r_line_px    <= 1'b0;
            r_pixel      <= 8'h00;
            r_wen        <= 1'b0;
            r_xo         <= 10'd0;
            r_yo         <= 10'd0;
            r_addr       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_vsync_d    <= CAM_VSYNC;
            r_armed      <= r_armed | CAM_VSYNC;
            // y is still the finished frame's line count at the rising edge
            r_frame_done <= w_vs_rise && (r_y != 10'd0);
            r_wen        <= 1'b0;
            if (w_clear) begin
                r_x       <= 10'd0;
                r_y       <= 10'd0;
                r_base    <= '0;
                r_line_px <= 1'b0;
            end else if (w_hi_latch) begin
                r_hi <= CAM_DATA;
            end else if (w_pix_done) begin
                r_line_px <= 1'b1;
                if (r_x < LP_W10) begin
                    r_x <= r_x + 10'd1;
                end else begin
                    r_x <= r_x;
                end
                if (w_in_window) begin
                    r_wen   <= 1'b1;
                    r_pixel <= {r_hi[7:5], r_hi[2:0], CAM_DATA[4:3]};
                    r_xo    <= r_x;
                    r_yo    <= r_y;
                    r_addr  <= r_base + ADDR_W'(r_x);
                end else begin
                    r_pixel <= r_pixel;
                end
            end else if (w_line_end) begin
                r_x       <= 10'd0;
                r_line_px <= 1'b0;
                // A pending hi byte of an odd-length line is simply dropped
                if (r_line_px && (r_y < LP_H10)) begin
                    r_y    <= r_y + 10'd1;
                    r_base <= r_base + LP_W_AD;
                end else begin
                    r_y <= r_y;
                end
            end else begin
                r_hi <= r_hi;
            end
        end
    end

    assign PIXEL_OUT  = r_pixel;
    assign W_EN       = r_wen;
    assign X_ADDR     = r_xo;
    assign Y_ADDR     = r_yo;
    assign WRITE_ADDR = r_addr;
    assign FRAME_DONE = r_frame_done;

endmodule

// File: tb/tb_cam_downsampler.sv
// -----------------------------------------------------------------------------
// tb_cam_downsampler
//   Drives randomized camera frames and lines into cam_downsampler. The bench
//   predicts every frame-buffer write from line/pixel indices (row*WIDTH+col)
//   and predicts FRAME_DONE pulses. A monitor compares all outputs every cycle
//   against that prediction, and literal checks pin the prediction against
//   hand-computed values.
// -----------------------------------------------------------------------------
module tb_cam_downsampler;

    localparam int W = 176;
    localparam int H = 144;

    logic        CLK       = 1'b0;
    logic        RESET_N   = 1'b1;
    logic [7:0]  CAM_DATA  = 8'h00;
    logic        CAM_HREF  = 1'b0;
    logic        CAM_VSYNC = 1'b1;
    logic [7:0]  PIXEL_OUT;
    logic        W_EN;
    logic [9:0]  X_ADDR;
    logic [9:0]  Y_ADDR;
    logic [14:0] WRITE_ADDR;
    logic        FRAME_DONE;

    cam_downsampler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .ADDR_W(15)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CAM_DATA(CAM_DATA), .CAM_HREF(CAM_HREF),
        .CAM_VSYNC(CAM_VSYNC), .PIXEL_OUT(PIXEL_OUT), .W_EN(W_EN), .X_ADDR(X_ADDR),
        .Y_ADDR(Y_ADDR), .WRITE_ADDR(WRITE_ADDR), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] pix;
        int         x;
        int         y;
        int         addr;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] byte_q[$];
    logic [7:0] last_pix   = 8'h00;
    int         last_x     = 0;
    int         last_y     = 0;
    int         last_addr  = 0;
    int         fd_cyc     = -1;
    int         tests      = 0;
    int         fails      = 0;
    int         writes_seen = 0;
    int         fd_seen    = 0;
    bit         capture_ok = 1'b0;
    int         line_idx   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RGB565 hi/lo byte pair to RGB332 using plain arithmetic on the fields
    function automatic logic [7:0] pack(input logic [7:0] hi, input logic [7:0] lo);
        int h;
        int l;
        h = int'(hi);
        l = int'(lo);
        return 8'((h / 32) * 32 + (h % 8) * 4 + (l / 8) % 4);
    endfunction

    // Per-cycle comparison of all outputs against the predicted write stream
    always @(posedge CLK) begin
        bit  exp_wen;
        wr_t e;
        #1;
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL missed_write: expected write at cycle %0d, now %0d", exp_q[0].cyc, cyc);
            void'(exp_q.pop_front());
        end
        exp_wen = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
        chk("w_en", 32'(W_EN), 32'(exp_wen));
        if (exp_wen) begin
            e         = exp_q.pop_front();
            last_pix  = e.pix;
            last_x    = e.x;
            last_y    = e.y;
            last_addr = e.addr;
        end
        chk("pixel_out", 32'(PIXEL_OUT), 32'(last_pix));
        chk("x_addr", 32'(X_ADDR), last_x);
        chk("y_addr", 32'(Y_ADDR), last_y);
        chk("write_addr", 32'(WRITE_ADDR), last_addr);
        chk("frame_done", 32'(FRAME_DONE), 32'(cyc == fd_cyc));
        if (W_EN === 1'b1) writes_seen++;
        if (FRAME_DONE === 1'b1) fd_seen++;
    end

    task automatic drive(input logic vs, input logic href, input logic [7:0] d);
        @(negedge CLK);
        CAM_VSYNC = vs;
        CAM_HREF  = href;
        CAM_DATA  = d;
    endtask

    task automatic vsync_pulse(input int hi_n, input int lo_n);
        logic prev;
        prev = CAM_VSYNC;
        for (int i = 0; i < hi_n; i++) begin
            drive(1'b1, 1'b0, 8'($urandom));
            if (i == 0 && prev == 1'b0 && line_idx > 0) fd_cyc = cyc + 1;
        end
        line_idx = 0;
        for (int i = 0; i < lo_n; i++) drive(1'b0, 1'b0, 8'($urandom));
        capture_ok = 1'b1;
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
    endtask

    // Send byte_q as one HREF-high line followed by gap idle cycles
    task automatic send_line(input int gap);
        logic [7:0] hi;
        wr_t        e;
        int         n;
        n  = byte_q.size();
        hi = 8'h00;
        for (int b = 0; b < n; b++) begin
            drive(1'b0, 1'b1, byte_q[b]);
            if (b % 2 == 0) begin
                hi = byte_q[b];
            end else if (capture_ok && (b / 2) < W && line_idx < H) begin
                e.cyc  = cyc + 1;
                e.pix  = pack(hi, byte_q[b]);
                e.x    = b / 2;
                e.y    = line_idx;
                e.addr = line_idx * W + b / 2;
                exp_q.push_back(e);
            end
        end
        for (int g = 0; g < gap; g++) drive(1'b0, 1'b0, 8'($urandom));
        if (capture_ok && n >= 2) line_idx++;
        byte_q.delete();
    endtask

    task automatic async_reset_check();
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("rst_pixel", 32'(PIXEL_OUT), 32'd0);
        chk("rst_wen", 32'(W_EN), 32'd0);
        chk("rst_x", 32'(X_ADDR), 32'd0);
        chk("rst_y", 32'(Y_ADDR), 32'd0);
        chk("rst_addr", 32'(WRITE_ADDR), 32'd0);
        chk("rst_fd", 32'(FRAME_DONE), 32'd0);
        exp_q.delete();
        last_pix   = 8'h00;
        last_x     = 0;
        last_y     = 0;
        last_addr  = 0;
        fd_cyc     = -1;
        capture_ok = 1'b0;
        line_idx   = 0;
    endtask

    initial begin
        int ws;
        int fd0;
        #1 RESET_N = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        chk("reset_pixel", 32'(PIXEL_OUT), 32'd0);
        chk("reset_addr", 32'(WRITE_ADDR), 32'd0);
        chk("reset_fd", 32'(FRAME_DONE), 32'd0);
        @(negedge CLK);
        #2 RESET_N = 1'b1;

        // First VSYNC after reset: no captured lines, so no FRAME_DONE
        vsync_pulse(3, 2);

        // Single pixels with hand-packed values
        byte_q = '{8'hF8, 8'h00};
        send_line(2);
        chk("t1_pixel", 32'(PIXEL_OUT), 32'hE0);
        chk("t1_xy", {6'd0, Y_ADDR, 6'd0, X_ADDR}, 32'd0);
        chk("t1_addr", 32'(WRITE_ADDR), 32'd0);
        chk("t1_count", writes_seen, 32'd1);
        byte_q = '{8'h07, 8'hFF};
        send_line(1);
        chk("t2_pixel", 32'(PIXEL_OUT), 32'h1F);
        chk("t2_y", 32'(Y_ADDR), 32'd1);
        chk("t2_addr", 32'(WRITE_ADDR), 32'd176);
        byte_q = '{8'hFF, 8'hFF};
        send_line(1);
        chk("t2_pixel_ff", 32'(PIXEL_OUT), 32'hFF);

        // 180-pixel line clipped to 176 writes
        ws = writes_seen;
        fill_random(360);
        send_line(3);
        chk("t3_writes", writes_seen - ws, 32'd176);
        chk("t3_last_x", 32'(X_ADDR), 32'd175);
        chk("t3_addr", 32'(WRITE_ADDR), 32'd703);

        // Odd byte count: trailing hi byte discarded, next line restarts at x=0
        ws = writes_seen;
        fill_random(3);
        send_line(1);
        chk("t4_writes", writes_seen - ws, 32'd1);
        fill_random(6);
        send_line(1);
        chk("t4_x", 32'(X_ADDR), 32'd2);
        chk("t4_addr", 32'(WRITE_ADDR), 32'd882);

        // Random frames of random-length lines
        for (int f = 0; f < 3; f++) begin
            vsync_pulse($urandom_range(1, 4), $urandom_range(1, 3));
            for (int l = 0; l < int'($urandom_range(1, 12)); l++) begin
                fill_random($urandom_range(0, 400));
                send_line($urandom_range(1, 3));
            end
        end

        // Frame of only single-byte lines: no FRAME_DONE
        vsync_pulse(2, 2);
        for (int l = 0; l < 3; l++) begin
            fill_random(1);
            send_line(1);
        end
        fd0 = fd_seen;
        vsync_pulse(2, 2);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        chk("no_fd_empty_frame", fd_seen - fd0, 32'd0);

        // 150 lines: rows 0..142 short, 143 full, 144..149 dropped
        while (line_idx < 143) begin
            fill_random($urandom_range(1, 8));
            send_line($urandom_range(1, 2));
        end
        for (int l = 0; l < 7; l++) begin
            ws = writes_seen;
            fill_random(352);
            send_line(1);
            if (l == 0) begin
                chk("t5_last_y", 32'(Y_ADDR), 32'd143);
                chk("t5_last_addr", 32'(WRITE_ADDR), 32'd25343);
            end
        end
        chk("t5_clipped_rows", writes_seen - ws, 32'd0);
        chk("t5_held_addr", 32'(WRITE_ADDR), 32'd25343);
        fd0 = fd_seen;
        vsync_pulse(3, 2);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        chk("t5_fd_once", fd_seen - fd0, 32'd1);

        // Reset in the middle of a line, released while HREF is high
        fill_random(20);
        send_line(1);
        drive(1'b0, 1'b1, 8'($urandom));
        async_reset_check();
        drive(1'b0, 1'b1, 8'($urandom));
        drive(1'b0, 1'b1, 8'($urandom));
        #2 RESET_N = 1'b1;
        ws = writes_seen;
        repeat (3) drive(1'b0, 1'b1, 8'($urandom));
        drive(1'b0, 1'b0, 8'h00);
        fill_random(40);
        send_line(2);
        chk("t6_no_writes", writes_seen - ws, 32'd0);
        vsync_pulse(2, 2);
        fill_random(10);
        send_line(2);
        chk("t6_writes", writes_seen - ws, 32'd5);
        chk("t6_addr", 32'(WRITE_ADDR), 32'd4);
        chk("t6_y", 32'(Y_ADDR), 32'd0);

        repeat (4) drive(1'b0, 1'b0, 8'h00);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
